// File: rtl/cxu_l2_slice_if.sv
// rtl/cxu_l2_slice_if.sv - CXU-L2 request/response bundle with requester (master) and responder (slave) views
interface cxu_l2_slice_if #(
  parameter int CXU_N_CXUS    = 1,
  parameter int CXU_N_STATES  = 1,
  parameter int CXU_FUNC_ID_W = 10,
  parameter int CXU_INSN_W    = 0,
  parameter int CXU_DATA_W    = 32
);
  localparam int CXU_CXU_ID_W   = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1;
  localparam int CXU_STATE_ID_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1;
  localparam int INSN_W         = (CXU_INSN_W > 0) ? CXU_INSN_W : 1;

  logic                      req_valid;
  logic                      req_ready;
  logic [CXU_CXU_ID_W-1:0]   req_cxu;
  logic [CXU_STATE_ID_W-1:0] req_state;
  logic [CXU_FUNC_ID_W-1:0]  req_func;
  logic [INSN_W-1:0]         req_insn;
  logic [CXU_DATA_W-1:0]     req_data0;
  logic [CXU_DATA_W-1:0]     req_data1;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [1:0]                resp_status;
  logic [CXU_DATA_W-1:0]     resp_data;

  modport master (
    output req_valid, req_cxu, req_state, req_func, req_insn, req_data0, req_data1,
    input  req_ready,
    input  resp_valid, resp_status, resp_data,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_cxu, req_state, req_func, req_insn, req_data0, req_data1,
    output req_ready,
    output resp_valid, resp_status, resp_data,
    input  resp_ready
  );
endinterface

// File: rtl/cxu_l2_slice.sv
// rtl/cxu_l2_slice.sv - Registered CXU-L2 slice: 2-deep request/response FIFOs with outstanding-request cap
// Define CXU_L2_SLICE_PERF_EN to add the perf_reqs/perf_gate_cycles/perf_resp_stall counters.
module cxu_l2_slice #(
  parameter int CXU_N_CXUS    = 1,
  parameter int CXU_N_STATES  = 1,
  parameter int CXU_FUNC_ID_W = 10,
  parameter int CXU_INSN_W    = 0,
  parameter int CXU_DATA_W    = 32,
  parameter int MAX_OUT       = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  cxu_l2_slice_if.slave  up,
  cxu_l2_slice_if.master dn
`ifdef CXU_L2_SLICE_PERF_EN
  ,
  output logic [31:0]    perf_reqs,
  output logic [31:0]    perf_gate_cycles,
  output logic [31:0]    perf_resp_stall
`endif
);
  localparam int CXU_CXU_ID_W   = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1;
  localparam int CXU_STATE_ID_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1;
  localparam int INSN_W         = (CXU_INSN_W > 0) ? CXU_INSN_W : 1;
  localparam int REQ_W          = CXU_CXU_ID_W + CXU_STATE_ID_W + CXU_FUNC_ID_W + INSN_W + 2 * CXU_DATA_W;
  localparam int RESP_W         = 2 + CXU_DATA_W;
  localparam int OUT_W          = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [1:0]        req_cnt_q, req_cnt_d;
  logic [1:0]        resp_cnt_q, resp_cnt_d;
  logic [REQ_W-1:0]  req_head_q, req_head_d, req_tail_q, req_tail_d, req_in;
  logic [RESP_W-1:0] resp_head_q, resp_head_d, resp_tail_q, resp_tail_d, resp_in;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              pres_q, pres_d;

  logic run, gate_open;
  logic up_req_ready, dn_req_valid, dn_resp_ready, up_resp_valid;
  logic req_push, req_pop, resp_push, resp_pop;

  // Readies stay low until the first clock edge after reset release.
  assign run           = (state_q == ST_RUN);
  assign up_req_ready  = run && (req_cnt_q != 2'd2);
  assign req_push      = up.req_valid && up_req_ready;
  assign gate_open     = pres_q || (out_q < OUT_MAX);
  assign dn_req_valid  = (req_cnt_q != 2'd0) && gate_open;
  assign req_pop       = dn_req_valid && dn.req_ready;
  assign dn_resp_ready = run && (resp_cnt_q != 2'd2);
  assign resp_push     = dn.resp_valid && dn_resp_ready;
  assign up_resp_valid = (resp_cnt_q != 2'd0);
  assign resp_pop      = up_resp_valid && up.resp_ready;

  assign req_in  = {up.req_cxu, up.req_state, up.req_func, up.req_insn, up.req_data0, up.req_data1};
  assign resp_in = {dn.resp_status, dn.resp_data};

  assign up.req_ready  = up_req_ready;
  assign dn.req_valid  = dn_req_valid;
  assign {dn.req_cxu, dn.req_state, dn.req_func, dn.req_insn, dn.req_data0, dn.req_data1} = req_head_q;
  assign dn.resp_ready = dn_resp_ready;
  assign up.resp_valid = up_resp_valid;
  assign {up.resp_status, up.resp_data} = resp_head_q;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT) begin
      state_d = ST_RUN;
    end
  end

  // Shift-register FIFO: head is always the presented entry; a push lands in the first free slot after any pop.
  always_comb begin
    req_head_d = req_head_q;
    req_tail_d = req_tail_q;
    req_cnt_d  = req_cnt_q;
    if (req_pop) begin
      req_head_d = req_tail_q;
    end
    if (req_push) begin
      if ((req_cnt_q == 2'd0) || ((req_cnt_q == 2'd1) && req_pop)) begin
        req_head_d = req_in;
      end else begin
        req_tail_d = req_in;
      end
    end
    case ({req_push, req_pop})
      2'b10:   req_cnt_d = req_cnt_q + 2'd1;
      2'b01:   req_cnt_d = req_cnt_q - 2'd1;
      default: req_cnt_d = req_cnt_q;
    endcase
  end

  always_comb begin
    resp_head_d = resp_head_q;
    resp_tail_d = resp_tail_q;
    resp_cnt_d  = resp_cnt_q;
    if (resp_pop) begin
      resp_head_d = resp_tail_q;
    end
    if (resp_push) begin
      if ((resp_cnt_q == 2'd0) || ((resp_cnt_q == 2'd1) && resp_pop)) begin
        resp_head_d = resp_in;
      end else begin
        resp_tail_d = resp_in;
      end
    end
    case ({resp_push, resp_pop})
      2'b10:   resp_cnt_d = resp_cnt_q + 2'd1;
      2'b01:   resp_cnt_d = resp_cnt_q - 2'd1;
      default: resp_cnt_d = resp_cnt_q;
    endcase
  end

  // A presented request keeps its gate decision so t_req_valid is never withdrawn before handshake.
  always_comb begin
    out_d  = out_q;
    pres_d = dn_req_valid && !dn.req_ready;
    if (req_pop && !resp_pop) begin
      out_d = out_q + OUT_ONE;
    end else if (resp_pop && !req_pop && (out_q != '0)) begin
      out_d = out_q - OUT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      req_cnt_q   <= 2'd0;
      req_head_q  <= '0;
      req_tail_q  <= '0;
      resp_cnt_q  <= 2'd0;
      resp_head_q <= '0;
      resp_tail_q <= '0;
      out_q       <= '0;
      pres_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      req_head_q  <= req_head_d;
      req_tail_q  <= req_tail_d;
      resp_cnt_q  <= resp_cnt_d;
      resp_head_q <= resp_head_d;
      resp_tail_q <= resp_tail_d;
      out_q       <= out_d;
      pres_q      <= pres_d;
    end
  end

`ifdef CXU_L2_SLICE_PERF_EN
  logic [31:0] perf_reqs_q, perf_gate_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reqs_q  <= 32'd0;
      perf_gate_q  <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (req_push) begin
        perf_reqs_q <= perf_reqs_q + 32'd1;
      end
      if ((req_cnt_q != 2'd0) && (out_q == OUT_MAX)) begin
        perf_gate_q <= perf_gate_q + 32'd1;
      end
      if (up_resp_valid && !up.resp_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_reqs        = perf_reqs_q;
  assign perf_gate_cycles = perf_gate_q;
  assign perf_resp_stall  = perf_stall_q;
`endif

`ifndef SYNTHESIS
  // A downstream response with nothing outstanding is still buffered; this flags the protocol breach.
  unsolicited_resp_a: assert property (@(posedge clk) disable iff (!rst_n) !(dn.resp_valid && (out_q == '0)));
`endif
endmodule

// File: tb/tb_cxu_l2_slice.sv
// tb/tb_cxu_l2_slice.sv - Scoreboard bench for cxu_l2_slice with a simple downstream CXU model
module tb_cxu_l2_slice;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cxu_l2_slice_if #(.CXU_DATA_W(32)) up_if ();
  cxu_l2_slice_if #(.CXU_DATA_W(32)) dn_if ();

`ifdef CXU_L2_SLICE_PERF_EN
  logic [31:0] perf_reqs, perf_gate_cycles, perf_resp_stall;
`endif

  cxu_l2_slice #(.MAX_OUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .up    (up_if),
    .dn    (dn_if)
`ifdef CXU_L2_SLICE_PERF_EN
    ,
    .perf_reqs        (perf_reqs),
    .perf_gate_cycles (perf_gate_cycles),
    .perf_resp_stall  (perf_resp_stall)
`endif
  );

  typedef struct packed {
    logic        cxu;
    logic        st;
    logic [9:0]  func;
    logic        insn;
    logic [31:0] d0;
    logic [31:0] d1;
  } req_t;

  req_t        exp_req_q[$];
  int          exp_req_cyc_q[$];
  logic [33:0] exp_resp_q[$];
  int          dn_resp_cyc_q[$];
  logic [33:0] dn_pend[$];
  logic [33:0] dn_hold[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int dn_hs = 0;
  int resp_seen = 0;
  int first_resp_cyc = 0;
  int last_resp_cyc = 0;
  bit lat_chk = 1'b0;
  bit dn_respond = 1'b1;
  bit dn_taken = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected event, want none", name);
  endtask

  // Monitor: every handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin : mon
    req_t        got;
    req_t        e;
    logic [33:0] er;
    int          c;
    if (rst_n) begin
      if (dn_if.req_valid && dn_if.req_ready) begin
        got = {dn_if.req_cxu, dn_if.req_state, dn_if.req_func, dn_if.req_insn, dn_if.req_data0, dn_if.req_data1};
        dn_hs++;
        if (exp_req_q.size() == 0) begin
          fail_now("t_req unexpected");
        end else begin
          e = exp_req_q.pop_front();
          c = exp_req_cyc_q.pop_front();
          check("t_req fields", got, e);
          if (lat_chk) check("t_req latency", cyc - c, 1);
        end
        if (dn_respond) dn_pend.push_back({got.func[1:0], got.d0});
        else dn_hold.push_back({got.func[1:0], got.d0});
      end
      if (dn_if.resp_valid && dn_if.resp_ready) begin
        dn_taken = 1'b1;
        dn_resp_cyc_q.push_back(cyc);
      end
      if (up_if.resp_valid && up_if.resp_ready) begin
        if (exp_resp_q.size() == 0) begin
          fail_now("resp unexpected");
        end else begin
          er = exp_resp_q.pop_front();
          check("resp status/data", {up_if.resp_status, up_if.resp_data}, er);
        end
        if (dn_resp_cyc_q.size() > 0) begin
          c = dn_resp_cyc_q.pop_front();
          if (lat_chk) check("resp latency", cyc - c, 1);
        end
        if (resp_seen == 0) first_resp_cyc = cyc;
        last_resp_cyc = cyc;
        resp_seen++;
      end
    end
  end

  // Downstream CXU model: answers with status=func[1:0], data=data0, one response per cycle.
  always @(posedge clk) begin
    #1;
    if (dn_taken) begin
      if (dn_pend.size() > 0) dn_pend.delete(0);
      dn_taken = 1'b0;
    end
    if (dn_pend.size() > 0) begin
      dn_if.resp_valid = 1'b1;
      {dn_if.resp_status, dn_if.resp_data} = dn_pend[0];
    end else begin
      dn_if.resp_valid  = 1'b0;
      dn_if.resp_status = 2'd0;
      dn_if.resp_data   = 32'd0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [9:0] f, input logic [31:0] d0, input logic [31:0] d1,
                          input logic cx, input logic st);
    int t = 0;
    up_if.req_valid = 1'b1;
    up_if.req_func  = f;
    up_if.req_data0 = d0;
    up_if.req_data1 = d1;
    up_if.req_cxu   = cx;
    up_if.req_state = st;
    up_if.req_insn  = 1'b0;
    @(negedge clk);
    while (!up_if.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!up_if.req_ready) begin
      fail_now("req accept");
    end else begin
      exp_req_q.push_back({cx, st, f, 1'b0, d0, d1});
      exp_req_cyc_q.push_back(cyc);
      exp_resp_q.push_back({f[1:0], d0});
    end
    @(posedge clk);
    #1;
    up_if.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_resp_q.size() != 0 || exp_req_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_resp_q.size() != 0 || exp_req_q.size() != 0) fail_now(name);
    tick(1);
  endtask

  task automatic release_held();
    while (dn_hold.size() > 0) dn_pend.push_back(dn_hold.pop_front());
  endtask

  initial begin
    int t;
    up_if.req_valid  = 1'b1;
    up_if.req_cxu    = 1'b0;
    up_if.req_state  = 1'b0;
    up_if.req_func   = 10'd0;
    up_if.req_insn   = 1'b0;
    up_if.req_data0  = 32'd0;
    up_if.req_data1  = 32'd0;
    up_if.resp_ready = 1'b1;
    dn_if.req_ready  = 1'b1;

    // Reset held with req_valid asserted
    repeat (3) begin
      @(negedge clk);
      check("reset req_ready", up_if.req_ready, 0);
      check("reset t_req_valid", dn_if.req_valid, 0);
      check("reset resp_valid", up_if.resp_valid, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    up_if.req_valid = 1'b0;
    tick(1);
    @(negedge clk);
    check("post-reset req_ready", up_if.req_ready, 1);
    check("post-reset t_resp_ready", dn_if.resp_ready, 1);
    tick(1);

    // Back-to-back streaming
    lat_chk = 1'b1;
    resp_seen = 0;
    for (int i = 0; i < 8; i++) send_req(10'd1, 32'hFFFF_0000 + i, i, i[0], i[1]);
    wait_drain("stream drain");
    check("stream resp count", resp_seen, 8);
    check("stream 1/cycle span", last_resp_cyc - first_resp_cyc, 7);
    lat_chk = 1'b0;

    // Status codes and sideband fields pass through untouched
    for (int i = 0; i < 4; i++) send_req(10'h3C0 | i, 32'h1234_0000 + 17 * i, ~(32'h1234_0000 + 17 * i), ~i[0], i[0]);
    wait_drain("status drain");

    // Outstanding cap: downstream accepts but holds responses
    dn_respond = 1'b0;
    resp_seen = 0;
    t = dn_hs;
    for (int i = 0; i < 6; i++) send_req(10'h002, 32'hC0DE_0000 + i, i, 1'b0, 1'b0);
    tick(5);
    @(negedge clk);
    check("cap t_req handshakes", dn_hs - t, 4);
    check("cap t_req_valid gated", dn_if.req_valid, 0);
    check("cap req_ready full", up_if.req_ready, 0);
    @(posedge clk);
    #1;
    dn_pend.push_back(dn_hold.pop_front());
    tick(6);
    @(negedge clk);
    check("cap one released", dn_hs - t, 5);
    check("cap regated", dn_if.req_valid, 0);
    check("cap req_ready", up_if.req_ready, 1);
    check("cap one resp", resp_seen, 1);
    @(posedge clk);
    #1;
    dn_respond = 1'b1;
    release_held();
    wait_drain("cap drain");

    // Upstream backpressure with three responses arriving
    up_if.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_req(10'h003, 32'hB0B0_0000 + i, 32'hFACE, 1'b1, 1'b0);
    tick(4);
    @(negedge clk);
    check("bp t_resp_ready", dn_if.resp_ready, 0);
    check("bp resp_valid", up_if.resp_valid, 1);
    check("bp third waiting", dn_if.resp_valid, 1);
    repeat (3) begin
      @(negedge clk);
      check("bp resp_data held", {up_if.resp_status, up_if.resp_data}, {2'd3, 32'hB0B0_0000});
    end
    @(posedge clk);
    #1;
    up_if.resp_ready = 1'b1;
    wait_drain("bp drain");

    // Reset with two requests and one response buffered
    up_if.resp_ready = 1'b0;
    send_req(10'h000, 32'hDEAD_0001, 32'd1, 1'b0, 1'b0);
    tick(3);
    dn_if.req_ready = 1'b0;
    send_req(10'h001, 32'hDEAD_0002, 32'd2, 1'b0, 1'b0);
    send_req(10'h002, 32'hDEAD_0003, 32'd3, 1'b0, 1'b0);
    tick(2);
    @(negedge clk);
    check("pre-rst req_ready", up_if.req_ready, 0);
    check("pre-rst resp_valid", up_if.resp_valid, 1);
    check("pre-rst t_req_valid", dn_if.req_valid, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_req_q.delete();
    exp_req_cyc_q.delete();
    exp_resp_q.delete();
    dn_resp_cyc_q.delete();
    dn_pend.delete();
    dn_hold.delete();
    dn_taken = 1'b0;
    #1;
    check("async rst t_req_valid", dn_if.req_valid, 0);
    check("async rst resp_valid", up_if.resp_valid, 0);
    check("async rst req_ready", up_if.req_ready, 0);
    check("async rst t_resp_ready", dn_if.resp_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    up_if.resp_ready = 1'b1;
    dn_if.req_ready = 1'b1;
    tick(6);
    @(negedge clk);
    check("post-rst no stale resp", up_if.resp_valid, 0);
    check("post-rst no stale req", dn_if.req_valid, 0);
    check("post-rst req_ready", up_if.req_ready, 1);
    tick(1);

`ifdef CXU_L2_SLICE_PERF_EN
    // Counters restart from the reset above
    dn_respond = 1'b0;
    for (int i = 0; i < 5; i++) send_req(10'h001, 32'h5EED_0000 + i, i, 1'b0, 1'b1);
    tick(3);
    up_if.resp_ready = 1'b0;
    dn_respond = 1'b1;
    release_held();
    t = 0;
    @(negedge clk);
    while (!up_if.resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!up_if.resp_valid) fail_now("perf resp_valid rise");
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    up_if.resp_ready = 1'b1;
    wait_drain("perf drain");
    @(negedge clk);
    check("perf_reqs", perf_reqs, 5);
    check("perf_resp_stall", perf_resp_stall, 7);
`endif

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, want $finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cxu_l2_slice.md
Name: cxu_l2_slice

Overview:
- Registered CXU-L2 pipeline slice between a CPU's CXU interface and a CXU-L2 streaming CXU (e.g. a cvt12/cvt01/bnn composition).
- Buffers requests and responses in 2-entry FIFOs, cutting every combinational path across the boundary.
- Caps outstanding requests so downstream CXUs with bounded response buffering are never overrun.
- Transparent to CXU semantics: fields pass unmodified, in order.

Parameters:
- CXU_N_CXUS, 1, number of CXUs; CXU_CXU_ID_W = max(1, $clog2(CXU_N_CXUS)).
- CXU_N_STATES, 1, states per CXU; CXU_STATE_ID_W = max(1, $clog2(CXU_N_STATES)).
- CXU_FUNC_ID_W, 10, function id width.
- CXU_INSN_W, 0, raw instruction width; 0 means the insn field is absent (1-bit tie-off, ignored).
- CXU_DATA_W, 32, operand/result width (32 or 64).
- MAX_OUT, 4, maximum requests in flight past the slice (1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  slice accepts upstream request.
- req_cxu  in  CXU_CXU_ID_W  CXU id.
- req_state  in  CXU_STATE_ID_W  state id.
- req_func  in  CXU_FUNC_ID_W  function id.
- req_insn  in  max(1,CXU_INSN_W)  raw insn.
- req_data0, req_data1  in  CXU_DATA_W  operands.
- resp_valid  out  1  upstream response valid.
- resp_ready  in  1  upstream accepts response.
- resp_status  out  2  CXU status.
- resp_data  out  CXU_DATA_W  result.
- t_req_valid, t_req_ready, t_req_cxu, t_req_state, t_req_func, t_req_insn, t_req_data0, t_req_data1: downstream request, mirror of req_* with directions reversed.
- t_resp_valid, t_resp_ready, t_resp_status, t_resp_data: downstream response, mirror of resp_* with directions reversed.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: req_ready=0 while rst_n=0, 1 from first cycle after release. All valids=0. FIFOs empty. Outstanding count=0. Data outputs don't-care.
- Request FIFO: 2 entries, in order; push on req_valid&req_ready.
  - req_ready = (req_count<2), a function of registered state only; no combinational ready-to-ready path.
  - Pop on t_req_valid&t_req_ready.
  - t_req_valid = (req_count>0) & (outstanding<MAX_OUT).
  - t_req_* fields come from the head register.
- Latency: request accepted in cycle N appears on t_req in cycle N+1 earliest; response accepted from downstream in cycle M appears on resp in M+1 earliest.
- Throughput: 1 request/cycle and 1 response/cycle sustained when nothing stalls.
- Response FIFO: 2 entries.
  - t_resp_ready = (resp_count<2).
  - resp_valid = (resp_count>0); resp_status/resp_data from the head entry.
  - Pop on resp_valid&resp_ready.
- Outstanding counter, width $clog2(MAX_OUT+1):
  - +1 on downstream request handshake; -1 on upstream response handshake; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUT: t_req_valid is gated when outstanding==MAX_OUT.
  - A response handshake in that same cycle does not ungate t_req_valid until the next cycle.
- Full FIFO: simultaneous push and pop on a full FIFO cannot occur, since ready is low. On a 1-entry FIFO, simultaneous push and pop leaves count=1 with the new data at head.
- Valid stability: once t_req_valid or resp_valid rises, it and its data hold until handshake.
  - Sole exception: t_req_valid may not rise while gated. Once raised it is never withdrawn, because gating only prevents new assertion.
  - Implementation: latch the gate decision while a request is presented.
- Unsolicited response (t_resp_valid while outstanding==0): still buffered. Outstanding saturates at 0, no underflow. Sim-only assertion fires.
- Status codes (OK, CXU error, state error, off) pass unmodified.
- Reset mid-operation: all buffered requests and responses discarded immediately; no handshake in progress completes.

Optional Feature:
- Macro: CXU_L2_SLICE_PERF_EN.
- Defined: adds three output ports.
  - perf_reqs [31:0]: counts upstream request handshakes.
  - perf_gate_cycles [31:0]: counts cycles with req_count>0 and outstanding==MAX_OUT.
  - perf_resp_stall [31:0]: counts cycles with resp_valid&!resp_ready.
  - All reset to 0 by rst_n and wrap modulo 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: rst_n low 3 cycles with req_valid=1 -> req_ready=0, t_req_valid=0, resp_valid=0; after release, req_ready=1 next cycle.
- Streaming: 8 back-to-back requests func=1, data0=0xFFFF0000+i, downstream always ready and responding next cycle -> 8 responses in order, 1/cycle steady-state, each first visible 1 cycle after its downstream handshake.
- Outstanding cap: MAX_OUT=4, downstream accepts but never responds -> exactly 4 t_req handshakes, then t_req_valid=0 and req_ready=0 after 2 more are buffered; one response releases exactly one more request.
- Backpressure: resp_ready=0 for 10 cycles with 3 responses arriving -> t_resp_ready drops after 2 buffered, no data lost, resp_data held stable; release drains in order.
- Mid-operation reset: assert rst_n low with 2 requests and 1 response buffered -> all valids 0 asynchronously; after release, no stale response emitted.
- PERF_EN: 5 requests, resp_ready stalled 7 cycles while resp_valid=1 -> perf_reqs=5, perf_resp_stall=7.
